// File: rtl/multicycle_ctrl_if.sv
// ALU control link: the controller selects the ALU operation and observes the zero flag.
interface multicycle_ctrl_if;
  logic [2:0] ALUControl;
  logic       zero;

  modport master (output ALUControl, input zero);
  modport slave  (input ALUControl, output zero);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: Moore main FSM with registered control outputs,
// plus combinational ALU and immediate-format decoders.
module multicycle_ctrl (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              op,
  input  logic [2:0]              funct3,
  input  logic                    funct7b5,
  multicycle_ctrl_if.master       alu,
  output logic                    PCWrite,
  output logic                    AdrSrc,
  output logic                    MemWrite,
  output logic                    IRWrite,
  output logic [1:0]              ResultSrc,
  output logic [1:0]              ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic                    RegWrite,
  output logic [1:0]              ImmSrc,
  output logic                    illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, HALT
  } state_t;

  typedef struct packed {
    logic       pcupd;
    logic       branch;
    logic       adrsrc;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [1:0] res;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] aluop;
    logic       ill;
  } ctl_t;

  state_t state_q, state_d;
  ctl_t   ctl_q;
  logic   f3_alu_ok;
  logic [2:0] alu_ctl;

  // Moore output table; evaluated on the next state so the outputs come straight from flops.
  function automatic ctl_t ctl_for(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.irw = 1'b1; c.srcb = 2'b10; c.res = 2'b10; c.pcupd = 1'b1; end
      DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
      MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
      MEMREAD:  begin c.adrsrc = 1'b1; end
      MEMWB:    begin c.res = 2'b01; c.regw = 1'b1; end
      MEMWRITE: begin c.adrsrc = 1'b1; c.memw = 1'b1; end
      EXECR:    begin c.srca = 2'b10; c.aluop = 2'b10; end
      EXECI:    begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = 2'b10; end
      ALUWB:    begin c.regw = 1'b1; end
      BEQ:      begin c.srca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
      JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcupd = 1'b1; end
      HALT:     begin c.ill = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign f3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = f3_alu_ok ? EXECR : HALT;
          OP_I:         state_d = f3_alu_ok ? EXECI : HALT;
          OP_BEQ:       state_d = (funct3 == 3'b000) ? BEQ : HALT;
          OP_JAL:       state_d = JAL;
          default:      state_d = HALT;
        endcase
      end
      MEMADR:                       state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:                      state_d = MEMWB;
      MEMWB, MEMWRITE, ALUWB, BEQ:  state_d = FETCH;
      EXECR, EXECI, JAL:            state_d = ALUWB;
      HALT:                         state_d = HALT;
      default:                      state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctl_q   <= ctl_for(FETCH);
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_for(state_d);
    end
  end

  always_comb begin
    alu_ctl = 3'b000;
    case (ctl_q.aluop)
      2'b01: alu_ctl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctl = {2'b00, op[5] & funct7b5};
          3'b110:  alu_ctl = 3'b011;
          3'b111:  alu_ctl = 3'b010;
          default: alu_ctl = 3'b000;
        endcase
      end
      default: alu_ctl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Enables are gated by rst_n so they drop the instant reset asserts, without waiting for an edge.
  assign PCWrite        = rst_n & (ctl_q.pcupd | (ctl_q.branch & alu.zero));
  assign IRWrite        = rst_n & ctl_q.irw;
  assign MemWrite       = rst_n & ctl_q.memw;
  assign RegWrite       = rst_n & ctl_q.regw;
  assign AdrSrc         = ctl_q.adrsrc;
  assign ResultSrc      = ctl_q.res;
  assign ALUSrcA        = ctl_q.srca;
  assign ALUSrcB        = ctl_q.srcb;
  assign illegal        = ctl_q.ill;
  assign alu.ALUControl = alu_ctl;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of directed instructions, reset/illegal corner sequences,
// and random instructions checked cycle by cycle against an instruction-level model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_ctrl_if ifc ();

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .alu(ifc), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_BAD = 6;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite,ImmSrc,illegal}
  logic [16:0] dut_vec;
  assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    ifc.ALUControl, RegWrite, ImmSrc, illegal};

  function automatic int cls_of(input logic [6:0] o, input logic [2:0] f);
    bit aluf3 = (f == 3'd0) || (f == 3'd6) || (f == 3'd7);
    if (o == LW) return C_LW;
    if (o == SW) return C_SW;
    if (o == RT) return aluf3 ? C_R : C_BAD;
    if (o == IT) return aluf3 ? C_I : C_BAD;
    if (o == BQ) return (f == 3'd0) ? C_BEQ : C_BAD;
    if (o == JL) return C_JAL;
    return C_BAD;
  endfunction

  function automatic int lat(input int c);
    case (c)
      C_LW:    return 5;
      C_BEQ:   return 3;
      C_BAD:   return 2;
      default: return 4;
    endcase
  endfunction

  // Arithmetic op of a register/immediate ALU instruction: 0 add, 1 sub, 2 and, 3 or.
  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f, input logic f7);
    if (f == 3'd6) return 3'd3;
    if (f == 3'd7) return 3'd2;
    return (o == RT && f7) ? 3'd1 : 3'd0;
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == SW) return 2'd1;
    if (o == BQ) return 2'd2;
    if (o == JL) return 2'd3;
    return 2'd0;
  endfunction

  // Expected outputs k cycles into an instruction (k=0 is the fetch cycle).
  function automatic logic [16:0] model(input logic [6:0] o, input logic [2:0] f,
                                        input logic f7, input logic z, input int k);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb;
    logic [2:0] ac;
    int c;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    res = 0; sa = 0; sb = 0; ac = 0;
    c = cls_of(o, f);
    if (k == 0) begin
      irw = 1; pcw = 1; sb = 2; res = 2;
    end else if (k == 1) begin
      sa = 1; sb = 1;
    end else if (c == C_BAD) begin
      ill = 1;
    end else begin
      case (c)
        C_LW, C_SW: begin
          if (k == 2) begin sa = 2; sb = 1; end
          else if (k == 3) begin adr = 1; mw = (c == C_SW); end
          else begin res = 1; rw = 1; end
        end
        C_R:   if (k == 2) begin sa = 2; ac = alu_of(o, f, f7); end else rw = 1;
        C_I:   if (k == 2) begin sa = 2; sb = 1; ac = alu_of(o, f, f7); end else rw = 1;
        C_BEQ: begin sa = 2; ac = 3'd1; pcw = z; end
        C_JAL: if (k == 2) begin sa = 1; sb = 2; pcw = 1; end else rw = 1;
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, res, sa, sb, ac, rw, imm_of(o), ill};
  endfunction

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Runs n cycles of one instruction starting in the fetch cycle; zmode 0/1 fixed zero, 2 random.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic f7,
                           input int zmode, input int n, input string nm,
                           input bit chk_x, input logic [2:0] ex_alu, input logic [1:0] ex_imm);
    logic z;
    op = o; funct3 = f; funct7b5 = f7;
    for (int k = 0; k < n; k++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      ifc.zero = z;
      #2;
      check($sformatf("%s_c%0d", nm, k), dut_vec, model(o, f, f7, z, k));
      if (chk_x && k == 0) check({nm, "_imm"}, {15'd0, ImmSrc}, {15'd0, ex_imm});
      if (chk_x && k == 2) check({nm, "_alu"}, {14'd0, ifc.ALUControl}, {14'd0, ex_alu});
      @(posedge clk); #1;
    end
    if (chk_x) begin
      #2;
      check({nm, "_refetch"}, {16'd0, IRWrite}, 17'd1);
    end
  endtask

  task automatic halt_check(input int cycles, input string nm);
    logic z;
    for (int k = 0; k < cycles; k++) begin
      z = 1'($urandom_range(0, 1));
      ifc.zero = z;
      #2;
      check($sformatf("%s_halt%0d", nm, k), dut_vec, model(op, funct3, funct7b5, z, 2));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    check({nm, "_rst_en"}, {12'd0, PCWrite, IRWrite, MemWrite, RegWrite, illegal}, 17'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         zmode;
    int         len;
    logic [2:0] ex_alu;
    logic [1:0] ex_imm;
    string      name;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [6:0] ro;
    logic [2:0] rf;
    logic       r7;
    int         c;

    tbl.push_back('{LW, 3'd2, 1'b0, 0, 5, 3'd0, 2'd0, "lw"});
    tbl.push_back('{SW, 3'd2, 1'b0, 0, 4, 3'd0, 2'd1, "sw"});
    tbl.push_back('{RT, 3'd0, 1'b1, 0, 4, 3'd1, 2'd0, "sub"});
    tbl.push_back('{RT, 3'd0, 1'b0, 0, 4, 3'd0, 2'd0, "add"});
    tbl.push_back('{RT, 3'd6, 1'b0, 0, 4, 3'd3, 2'd0, "or"});
    tbl.push_back('{RT, 3'd7, 1'b0, 0, 4, 3'd2, 2'd0, "and"});
    tbl.push_back('{IT, 3'd0, 1'b1, 0, 4, 3'd0, 2'd0, "addi_f7"});
    tbl.push_back('{IT, 3'd7, 1'b0, 0, 4, 3'd2, 2'd0, "andi"});
    tbl.push_back('{IT, 3'd6, 1'b0, 0, 4, 3'd3, 2'd0, "ori"});
    tbl.push_back('{BQ, 3'd0, 1'b0, 1, 3, 3'd1, 2'd2, "beq_taken"});
    tbl.push_back('{BQ, 3'd0, 1'b0, 0, 3, 3'd1, 2'd2, "beq_not"});
    tbl.push_back('{JL, 3'd5, 1'b1, 0, 4, 3'd0, 2'd3, "jal"});

    op = '0; funct3 = '0; funct7b5 = 1'b0; ifc.zero = 1'b0;
    do_reset("init");

    foreach (tbl[i])
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].zmode, tbl[i].len, tbl[i].name,
                1'b1, tbl[i].ex_alu, tbl[i].ex_imm);

    // Reset asserted while the store is writing: MemWrite must fall without a clock edge.
    op = SW; funct3 = 3'd2; funct7b5 = 1'b0; ifc.zero = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      check($sformatf("swrst_c%0d", k), dut_vec, model(SW, 3'd2, 1'b0, 1'b0, k));
      if (k < 3) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    #1;
    check("swrst_memwrite_drop", {16'd0, MemWrite}, 17'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(RT, 3'd0, 1'b1, 0, 4, "after_swrst", 1'b1, 3'd1, 2'd0);

    // Unsupported R-type funct3 halts until reset.
    run_instr(RT, 3'd4, 1'b0, 0, 2, "illegal", 1'b0, 3'd0, 2'd0);
    halt_check(20, "illegal");
    do_reset("illegal");
    run_instr(JL, 3'd0, 1'b0, 0, 4, "jal_after_halt", 1'b1, 3'd0, 2'd3);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0: ro = LW;
        1: ro = SW;
        2: ro = RT;
        3: ro = IT;
        4: ro = BQ;
        5: ro = JL;
        default: ro = 7'($urandom_range(0, 127));
      endcase
      rf = 3'($urandom_range(0, 7));
      r7 = 1'($urandom_range(0, 1));
      c  = cls_of(ro, rf);
      run_instr(ro, rf, r7, 2, lat(c), $sformatf("rnd%0d", i), 1'b0, 3'd0, 2'd0);
      if (c == C_BAD) begin
        halt_check(3, $sformatf("rnd%0d", i));
        do_reset($sformatf("rnd%0d", i));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
